// File: rtl/add_sum_stage.sv
// add_sum_stage: final sum stage of a pipelined prefix adder with a credit-controlled result FIFO.
//
// Operands enter on in_valid && in_ready. The propagate vector and carry-in travel down a
// LATENCY-deep delay line. They meet the resolved carry vector from the external prefix
// pipeline at the tail of that line. The finished {sum, cout, ovf} is pushed into a
// FIFO_DEPTH-entry buffer and drained through a valid/ready output port.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid, in_a[31:0], in_b[31:0], in_cin, in_ready   - operation input, credit-gated
//   carry[63:0]                                           - 2-bit resolved carry per bit (11=1, 00=0)
//   out_valid, out_ready, out_sum[31:0], out_cout, out_ovf - result output from FIFO head
//   err_unres                                             - sticky unresolved-carry flag
//
// Build option: define ADD_SUM_ERRCHK_EN to flag 01/10 carry pairs on a valid tail stage.
// Without it, err_unres is tied low and each pair is resolved by its MSB.
module add_sum_stage #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    output logic        in_ready,
    input  logic [63:0] carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        err_unres
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] ci_q, ci_d;
    logic [31:0]        p_q [LATENCY];
    logic [31:0]        p_d [LATENCY];
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]      cnt_q, cnt_d, inflight;
    logic               err_unres_q, err_unres_d;
    res_t               mem_q [FIFO_DEPTH];
    res_t               res;
    logic [31:0]        cres, unres;
    logic               accept, push, pop;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < LATENCY; k++) inflight = inflight + CW'(vld_q[k]);
        // Every valid stage already owns a FIFO slot, so credit covers the delay line too.
        in_ready = (cnt_q + inflight) < CW'(FIFO_DEPTH);
        accept = in_valid && in_ready;
        vld_d = LATENCY'({vld_q, accept});
        ci_d = LATENCY'({ci_q, in_cin});
        p_d[0] = in_a ^ in_b;
        for (int k = 1; k < LATENCY; k++) p_d[k] = p_q[k-1];
        for (int i = 0; i < 32; i++) begin
            cres[i] = carry[2*i+1];
            unres[i] = carry[2*i+1] ^ carry[2*i];
        end
        // Carry into bit i is the carry out of bit i-1; bit 0 takes the operation's cin.
        res.sum = p_q[LATENCY-1] ^ {cres[30:0], ci_q[LATENCY-1]};
        res.cout = cres[31];
        res.ovf = cres[30] ^ cres[31];
        push = vld_q[LATENCY-1];
        out_valid = cnt_q != '0;
        pop = out_valid && out_ready;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
`ifdef ADD_SUM_ERRCHK_EN
        err_unres_d = err_unres_q | (push & (|unres));
`else
        err_unres_d = 1'b0;
`endif
        {out_sum, out_cout, out_ovf} = out_valid ? mem_q[rd_q] : res_t'('0);
    end

`ifndef ADD_SUM_ERRCHK_EN
    logic unused_unres;
    assign unused_unres = |unres;
`endif

    assign err_unres = err_unres_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            err_unres_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            err_unres_q <= err_unres_d;
        end
    end

    // Payload registers carry no reset: their stage valid qualifies them.
    always_ff @(posedge clk) begin
        ci_q <= ci_d;
        p_q <= p_d;
        if (push) mem_q[wr_q] <= res;
    end
endmodule

// File: tb/tb_add_sum_stage.sv
// tb_add_sum_stage: randomized and directed self-checking bench for add_sum_stage.
module tb_add_sum_stage;
    localparam int L = 4;
    localparam int D = 8;
`ifdef ADD_SUM_ERRCHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] carry;
    logic        in_ready, out_valid, out_cout, out_ovf, err_unres;
    logic [31:0] out_sum;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    logic [33:0] exp_q[$];
    logic [63:0] stage [L];
    logic        acc_s = 1'b0;
    logic [63:0] car_s = '0;
    logic        corrupt = 1'b0;
    logic        hold_v = 1'b0;
    logic [33:0] hold_r = '0;

    always #5 clk = ~clk;

    add_sum_stage #(.LATENCY(L), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_ready(in_ready), .carry(carry), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .err_unres(err_unres)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result: 33-bit addition and the signed-overflow rule.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [32:0] s;
        logic        ovf;
        s = {1'b0, a} + {1'b0, b} + 33'(ci);
        ovf = (a[31] == b[31]) && (s[31] != a[31]);
        return {s[31:0], s[32], ovf};
    endfunction

    // Upstream prefix result: carry out of bit i from the sum of the low i+1 bits.
    function automatic logic [63:0] carries(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [63:0] v, m, s;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            m = (64'd1 << (i + 1)) - 64'd1;
            s = ({32'd0, a} & m) + ({32'd0, b} & m) + 64'(ci);
            v[2*i +: 2] = {2{s[i+1]}};
        end
        return v;
    endfunction

    assign carry = stage[L-1];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < L; k++) stage[k] <= '0;
        end else begin
            stage[0] <= acc_s ? car_s : '0;
            for (int k = 1; k < L; k++) stage[k] <= stage[k-1];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            acc_s = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) check("hold_stable", {out_valid, out_sum, out_cout, out_ovf}, {1'b1, hold_r});
            if (out_valid && out_ready) begin
                n_pop++;
                check("pop_has_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("result_order", {out_sum, out_cout, out_ovf}, exp_q.pop_front());
            end
            hold_v = out_valid && !out_ready;
            hold_r = {out_sum, out_cout, out_ovf};
            acc_s = in_valid && in_ready;
            if (acc_s) begin
                car_s = carries(in_a, in_b, in_cin) ^ (corrupt ? 64'h400 : 64'h0);
                exp_q.push_back(model(in_a, in_b, in_cin));
                n_acc++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand();
        case ($urandom_range(0, 5))
            0: in_a = 32'hFFFF_FFFF;
            1: in_a = 32'h7FFF_FFFF;
            default: in_a = $urandom;
        endcase
        in_b = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : $urandom;
        in_cin = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = ci;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            n++;
            next_cycle();
        end while (!acc && n < 200);
        check("send_accepted", acc, 1);
    endtask

    task automatic expect_out(input string tag, input logic [31:0] s, input logic co, input logic ov);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_result"}, {out_sum, out_cout, out_ovf}, {s, co, ov});
        next_cycle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            next_cycle();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
        next_cycle();
    endtask

    task automatic stream(input int n_ops, input int max_cycles, output int cycles);
        int   got;
        logic acc;
        got = 0;
        cycles = 0;
        in_valid = 1'b1;
        set_rand();
        while (got < n_ops && cycles < max_cycles) begin
            @(negedge clk);
            acc = in_ready;
            cycles++;
            next_cycle();
            if (acc) begin
                got++;
                set_rand();
            end
        end
        in_valid = 1'b0;
    endtask

    int base, pbase, cyc, n;
    logic seen;

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fields", {out_sum, out_cout, out_ovf}, 0);
        check("rst_err", err_unres, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);
        next_cycle();

        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = 32'hFFFF_FFFF;
        in_b = 32'h0000_0001;
        in_cin = 1'b0;
        @(negedge clk);
        check("lat_accept", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) check("lat_early", out_valid, 0);
            else begin
                check("lat_valid", out_valid, 1);
                check("lat_result", {out_sum, out_cout, out_ovf}, {32'h0, 1'b1, 1'b0});
            end
        end
        next_cycle();

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        in_valid = 1'b0;
        expect_out("ovf", 32'h8000_0000, 1'b0, 1'b1);
        send(32'h0, 32'h0, 1'b1);
        in_valid = 1'b0;
        expect_out("cin", 32'h0000_0001, 1'b0, 1'b0);
        drain();

        out_ready = 1'b0;
        base = n_acc;
        pbase = n_pop;
        stream(12, 20, cyc);
        check("full_accepts", 64'(n_acc - base), 8);
        check("full_ready_low", in_ready, 0);
        out_ready = 1'b1;
        stream(4, 100, cyc);
        drain();
        check("full_total_accepts", 64'(n_acc - base), 12);
        check("full_total_pops", 64'(n_pop - pbase), 12);

        out_ready = 1'b0;
        stream(8, 20, cyc);
        repeat (L + 2) next_cycle();
        check("buf_full_valid", out_valid, 1);
        check("buf_full_ready", in_ready, 0);
        out_ready = 1'b1;
        stream(20, 200, cyc);
        drain();

        base = n_acc;
        stream(16, 100, cyc);
        check("throughput_cycles", 64'(cyc), 16);
        check("throughput_accepts", 64'(n_acc - base), 16);
        drain();

        in_valid = 1'b0;
        repeat (300) begin
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                set_rand();
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            seen = in_valid && in_ready;
            next_cycle();
            if (seen) in_valid = 1'b0;
        end
        drain();

        check("err_before", err_unres, 0);
        corrupt = 1'b1;
        send($urandom, $urandom, 1'b0);
        corrupt = 1'b0;
        in_valid = 1'b0;
        drain();
        check("err_set", err_unres, EXP_ERR);
        repeat (5) next_cycle();
        check("err_sticky", err_unres, EXP_ERR);

        out_ready = 1'b0;
        send($urandom, $urandom, 1'b1);
        send($urandom, $urandom, 1'b0);
        in_valid = 1'b0;
        repeat (L + 2) next_cycle();
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b1);
        send($urandom, $urandom, 1'b0);
        in_valid = 1'b0;
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err", err_unres, 0);
        check("midrst_fields", {out_sum, out_cout, out_ovf}, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", in_ready, 1);
        out_ready = 1'b1;
        seen = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | out_valid;
            n++;
        end
        check("midrst_no_ghost", seen, 0);
        check("midrst_window", 64'(n), 20);

        repeat (3) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
